// File: rtl/countdown_timer_ctrl_pkg.sv
// Shared types and constants for the countdown timer controller.
// Key bit positions match the debouncer's level-valid key vector.
package timer_pkg;

  typedef enum logic [2:0] {
    SET,
    RUN,
    WARN,
    PAUSE,
    DONE
  } state_e;

  localparam int unsigned KEY_W     = 10;
  localparam int unsigned KEY_INC   = 0;
  localparam int unsigned KEY_DEC   = 1;
  localparam int unsigned KEY_LEFT  = 2;
  localparam int unsigned KEY_RIGHT = 3;
  localparam int unsigned KEY_PAUSE = 4;
  localparam int unsigned KEY_START = 5;
  localparam int unsigned KEY_ABORT = 9;

  function automatic int unsigned pow10(input int unsigned i);
    int unsigned r;
    r = 1;
    for (int unsigned k = 0; k < i; k++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/countdown_timer_ctrl_if.sv
// Key/mode inputs and display outputs between the debouncer,
// the timer controller and the seven-segment scan block.
interface countdown_timer_ctrl_if
  import timer_pkg::*;
#(
  parameter int unsigned N_DIG = 6,
  parameter int unsigned VAL_W = 20
);

  logic [KEY_W-1:0] key_state;
  logic             count_up;
  logic [N_DIG-1:0] point_position;
  logic [N_DIG-1:0] shank_position;
  logic [VAL_W-1:0] number_to_show;
  logic             warn;
  logic             done;

  modport master (
    output key_state,
    output count_up,
    input  point_position,
    input  shank_position,
    input  number_to_show,
    input  warn,
    input  done
  );

  modport slave (
    input  key_state,
    input  count_up,
    output point_position,
    output shank_position,
    output number_to_show,
    output warn,
    output done
  );

endinterface

// File: rtl/countdown_timer_ctrl_key_edge_detect.sv
// Rising-edge detector for a vector of debounced key levels.
module key_edge_detect #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_level,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Timer controller: preset editing, run/warn/pause/done sequencing
// and registered display outputs for the seven-segment scanner.
module countdown_timer_ctrl #(
  parameter int unsigned N_DIG      = 6,
  parameter int unsigned VAL_W      = 20,
  parameter int unsigned MAX_VAL    = 999999,
  parameter int unsigned TICK_DIV   = 10,
  parameter int unsigned WARN_TH    = 300,
  parameter int unsigned POINT_MASK = 0
) (
  input logic                   clk,
  input logic                   rst_n,
  countdown_timer_ctrl_if.slave bus
);
  import timer_pkg::*;

  localparam int unsigned IDX_W =
    (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int unsigned TICK_W =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(N_DIG - 1);
  localparam logic [TICK_W-1:0] TICK_LAST =
    TICK_W'(TICK_DIV - 1);
  localparam logic [VAL_W:0] MAX_EXT =
    (VAL_W + 1)'(MAX_VAL);
  localparam logic [VAL_W-1:0] WARN_V =
    VAL_W'(WARN_TH);

  state_e            r_state;
  state_e            r_ret;
  logic [VAL_W-1:0]  r_preset;
  logic [IDX_W-1:0]  r_idx;
  logic [TICK_W-1:0] r_tick;
  logic [VAL_W-1:0]  r_count;
  logic              r_up;
  logic              r_phase;
  logic [VAL_W-1:0]  r_num;
  logic [N_DIG-1:0]  r_shank;
  logic              r_warn;
  logic              r_done;

  state_e            n_state;
  state_e            n_ret;
  logic [VAL_W-1:0]  n_preset;
  logic [IDX_W-1:0]  n_idx;
  logic [TICK_W-1:0] n_tick;
  logic [VAL_W-1:0]  n_count;
  logic              n_up;
  logic              n_phase;
  logic [VAL_W-1:0]  n_num;
  logic [N_DIG-1:0]  n_shank;
  logic              n_warn;
  logic              n_done;

  logic [KEY_W-1:0]  w_rise;
  logic              w_unused;
  logic              w_inc;
  logic              w_dec;
  logic              w_left;
  logic              w_right;
  logic              w_start;
  logic              w_abort;
  logic              w_pause;
  logic [VAL_W-1:0]  w_wt [N_DIG];
  logic [VAL_W-1:0]  w_cur;
  logic [VAL_W:0]    w_sum;
  logic              w_step;
  logic [TICK_W-1:0] w_tick_nx;
  logic [VAL_W-1:0]  w_cnt_nx;
  logic [VAL_W-1:0]  w_rem_nx;
  logic              w_go;
  logic              w_to_set;

  key_edge_detect #(
    .W (KEY_W)
  ) u_keys (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_level (bus.key_state),
    .o_rise  (w_rise)
  );

  // Reserved keys and the level-only pause key have no edge use.
  assign w_unused = ^{w_rise[8:6], w_rise[KEY_PAUSE]};

  assign w_inc   = w_rise[KEY_INC];
  assign w_dec   = w_rise[KEY_DEC];
  assign w_left  = w_rise[KEY_LEFT];
  assign w_right = w_rise[KEY_RIGHT];
  assign w_start = w_rise[KEY_START];
  assign w_abort = w_rise[KEY_ABORT];
  assign w_pause = bus.key_state[KEY_PAUSE];

  for (genvar g = 0; g < N_DIG; g++) begin : g_wt
    assign w_wt[g] = VAL_W'(pow10(N_DIG - 1 - g));
  end

  assign w_cur = w_wt[r_idx];
  // One spare bit so the saturation test sees past MAX_VAL.
  assign w_sum = {1'b0, r_preset} + {1'b0, w_cur};

  assign w_step    = (r_tick == TICK_LAST);
  assign w_tick_nx = w_step ? '0 : r_tick + 1'b1;
  assign w_cnt_nx  = !w_step ? r_count :
                     r_up    ? r_count + 1'b1 :
                               r_count - 1'b1;
  assign w_rem_nx  = r_up ? r_preset - w_cnt_nx
                          : w_cnt_nx;

  always_comb begin
    n_state  = r_state;
    n_ret    = r_ret;
    n_preset = r_preset;
    n_idx    = r_idx;
    n_tick   = r_tick;
    n_count  = r_count;
    n_up     = r_up;
    n_phase  = r_phase;
    w_go     = 1'b0;
    w_to_set = 1'b0;

    unique case (r_state)
      SET: begin
        if (w_inc && !w_dec) begin
          if (w_sum <= MAX_EXT) begin
            n_preset = w_sum[VAL_W-1:0];
          end
        end else if (w_dec && !w_inc) begin
          if (r_preset >= w_cur) begin
            n_preset = r_preset - w_cur;
          end
        end
        if (w_right && !w_left) begin
          n_idx = (r_idx == IDX_LAST) ? '0
                : r_idx + 1'b1;
        end else if (w_left && !w_right) begin
          n_idx = (r_idx == '0) ? IDX_LAST
                : r_idx - 1'b1;
        end
        w_go = w_start;
      end
      RUN, WARN: begin
        if (w_abort) begin
          w_to_set = 1'b1;
        end else if (w_pause) begin
          n_ret   = r_state;
          n_state = PAUSE;
        end else begin
          n_tick  = w_tick_nx;
          n_count = w_cnt_nx;
          if (r_state == WARN && w_step) begin
            n_phase = ~r_phase;
          end
          if (w_rem_nx == '0) begin
            n_state = DONE;
          end else if (w_rem_nx <= WARN_V) begin
            n_state = WARN;
          end
        end
      end
      PAUSE: begin
        if (w_abort) begin
          w_to_set = 1'b1;
        end else if (!w_pause) begin
          n_state = r_ret;
        end
      end
      DONE: begin
        if (w_abort) begin
          w_to_set = 1'b1;
        end else begin
          w_go = w_start;
        end
      end
      default: begin
        n_state = SET;
      end
    endcase

    if (w_to_set) begin
      n_state = SET;
      n_tick  = '0;
      n_phase = 1'b0;
    end

    if (w_go) begin
      n_up    = bus.count_up;
      n_count = bus.count_up ? '0 : n_preset;
      n_tick  = '0;
      n_phase = 1'b0;
      n_state = (n_preset == '0) ? DONE : RUN;
    end
  end

  always_comb begin
    n_num   = r_num;
    n_shank = r_shank;
    n_warn  = 1'b0;
    n_done  = 1'b0;
    unique case (n_state)
      SET: begin
        n_num   = n_preset;
        n_shank = N_DIG'(1) << n_idx;
      end
      RUN: begin
        n_num   = n_count;
        n_shank = '0;
      end
      WARN: begin
        n_num   = n_count;
        n_shank = {N_DIG{n_phase}};
        n_warn  = 1'b1;
      end
      PAUSE: begin
        n_warn = (n_ret == WARN);
      end
      DONE: begin
        n_num   = n_count;
        n_shank = '1;
        n_done  = 1'b1;
      end
      default: begin
        n_num = r_num;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= SET;
      r_ret    <= SET;
      r_preset <= '0;
      r_idx    <= IDX_LAST;
      r_tick   <= '0;
      r_count  <= '0;
      r_up     <= 1'b0;
      r_phase  <= 1'b0;
      r_num    <= '0;
      r_shank  <= '0;
      r_warn   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= n_state;
      r_ret    <= n_ret;
      r_preset <= n_preset;
      r_idx    <= n_idx;
      r_tick   <= n_tick;
      r_count  <= n_count;
      r_up     <= n_up;
      r_phase  <= n_phase;
      r_num    <= n_num;
      r_shank  <= n_shank;
      r_warn   <= n_warn;
      r_done   <= n_done;
    end
  end

  assign bus.point_position = N_DIG'(POINT_MASK);
  assign bus.number_to_show = r_num;
  assign bus.shank_position = r_shank;
  assign bus.warn           = r_warn;
  assign bus.done           = r_done;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Scoreboard bench for countdown_timer_ctrl: preset editing,
// down/up runs, warning blink, pause, abort and reset.
module tb_countdown_timer_ctrl;
  import timer_pkg::*;

  localparam int ND = 6;
  localparam int VW = 20;
  localparam int TD = 10;
  localparam int ALL = 63;

  localparam logic [9:0] K_INC   = 10'd1;
  localparam logic [9:0] K_DEC   = 10'd2;
  localparam logic [9:0] K_LEFT  = 10'd4;
  localparam logic [9:0] K_RIGHT = 10'd8;
  localparam logic [9:0] K_PAUSE = 10'd16;
  localparam logic [9:0] K_START = 10'd32;
  localparam logic [9:0] K_RSV   = 10'd256;
  localparam logic [9:0] K_ABORT = 10'd512;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  countdown_timer_ctrl_if #(
    .N_DIG (ND),
    .VAL_W (VW)
  ) bus ();

  countdown_timer_ctrl #(
    .N_DIG      (ND),
    .VAL_W      (VW),
    .MAX_VAL    (999999),
    .TICK_DIV   (TD),
    .WARN_TH    (300),
    .POINT_MASK (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string          name;
    int             cyc;
    logic [VW-1:0]  num;
    logic [ND-1:0]  shank;
    logic           warn;
    logic           done;
  } exp_t;

  exp_t sb[$];
  int n_run;
  int n_fail;
  int m_preset;
  int m_idx;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input int c,
                      input int num, input int shank,
                      input logic w, input logic d);
    exp_t e;
    e.name  = nm;
    e.cyc   = c;
    e.num   = VW'(num);
    e.shank = ND'(shank);
    e.warn  = w;
    e.done  = d;
    sb.push_back(e);
  endtask

  task automatic press(input logic [9:0] k);
    bus.key_state = k;
    cyc(1);
    bus.key_state = '0;
    cyc(1);
  endtask

  task automatic do_reset();
    bus.key_state = '0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    m_preset = 0;
    m_idx = ND - 1;
  endtask

  function automatic void m_edit(input logic [9:0] k);
    int w;
    w = 10 ** (ND - 1 - m_idx);
    if (k[0] && !k[1] && m_preset + w <= 999999)
      m_preset = m_preset + w;
    else if (k[1] && !k[0] && m_preset >= w)
      m_preset = m_preset - w;
    if (k[3] && !k[2])
      m_idx = (m_idx + 1) % ND;
    else if (k[2] && !k[3])
      m_idx = (m_idx + ND - 1) % ND;
  endfunction

  task automatic test_reset();
    exp_t e;
    #2;
    rst_n = 1'b0;
    #1;
    push("reset", 0, 0, 0, 0, 0);
    e = sb.pop_front();
    n_run++;
    if ({bus.number_to_show, bus.shank_position, bus.warn,
         bus.done} !== {e.num, e.shank, e.warn, e.done}) begin
      n_fail++;
      $display("FAIL %s: num=%0d shank=%b warn=%b done=%b, want num=%0d shank=%b warn=%b done=%b",
               e.name, bus.number_to_show, bus.shank_position,
               bus.warn, bus.done, e.num, e.shank, e.warn, e.done);
    end
    n_run++;
    if (bus.point_position !== 6'b000000) begin
      n_fail++;
      $display("FAIL point: got %b want 000000",
               bus.point_position);
    end
    rst_n = 1'b1;
    m_preset = 0;
    m_idx = ND - 1;
    push("set_entry", 1, 0, 32, 0, 0);
    cyc(1);
    e = sb.pop_front();
    n_run++;
    if ({bus.number_to_show, bus.shank_position, bus.warn,
         bus.done} !== {e.num, e.shank, e.warn, e.done}) begin
      n_fail++;
      $display("FAIL %s: num=%0d shank=%b warn=%b done=%b, want num=%0d shank=%b warn=%b done=%b",
               e.name, bus.number_to_show, bus.shank_position,
               bus.warn, bus.done, e.num, e.shank, e.warn, e.done);
    end
  endtask

  task automatic run_keys(input string nm, input logic [9:0] q[$]);
    exp_t e;
    for (int i = 0; i < q.size(); i++) begin
      m_edit(q[i]);
      push(nm, i, m_preset, 1 << m_idx, 0, 0);
      press(q[i]);
      e = sb.pop_front();
      n_run++;
      if ({bus.number_to_show, bus.shank_position, bus.warn,
           bus.done} !== {e.num, e.shank, e.warn, e.done}) begin
        n_fail++;
        $display("FAIL %s#%0d: num=%0d shank=%b warn=%b done=%b, want num=%0d shank=%b warn=%b done=%b",
                 e.name, e.cyc, bus.number_to_show, bus.shank_position,
                 bus.warn, bus.done, e.num, e.shank, e.warn, e.done);
      end
    end
  endtask

  task automatic test_edit();
    logic [9:0] q[$];
    do_reset();
    q = '{K_RIGHT, K_RIGHT, K_RIGHT, K_INC,
          K_LEFT, K_INC, K_INC};
    run_keys("edit", q);
  endtask

  task automatic test_saturate();
    logic [9:0] q[$];
    do_reset();
    q.push_back(K_RIGHT);
    q.push_back(K_DEC);
    for (int d = 0; d < ND; d++) begin
      repeat (9) q.push_back(K_INC);
      q.push_back(K_RIGHT);
    end
    q.push_back(K_LEFT);
    q.push_back(K_INC);
    q.push_back(K_INC | K_DEC);
    q.push_back(K_LEFT | K_RIGHT);
    q.push_back(K_PAUSE);
    q.push_back(K_ABORT);
    q.push_back(K_RSV);
    q.push_back(K_DEC);
    q.push_back(K_INC);
    run_keys("sat", q);
  endtask

  task automatic test_zero_start();
    exp_t e;
    logic [9:0] ks [3];
    logic ups [3];
    ks = '{K_START, K_START, K_ABORT};
    ups = '{1'b0, 1'b1, 1'b0};
    do_reset();
    push("zero_dn", 0, 0, ALL, 0, 1);
    push("zero_up", 1, 0, ALL, 0, 1);
    push("zero_ab", 2, 0, 32, 0, 0);
    for (int i = 0; i < 3; i++) begin
      bus.count_up = ups[i];
      bus.key_state = ks[i];
      cyc(1);
      bus.key_state = '0;
      e = sb.pop_front();
      n_run++;
      if ({bus.number_to_show, bus.shank_position, bus.warn,
           bus.done} !== {e.num, e.shank, e.warn, e.done}) begin
        n_fail++;
        $display("FAIL %s: num=%0d shank=%b warn=%b done=%b, want num=%0d shank=%b warn=%b done=%b",
                 e.name, bus.number_to_show, bus.shank_position,
                 bus.warn, bus.done, e.num, e.shank, e.warn, e.done);
      end
      cyc(1);
    end
  endtask

  task automatic test_down_warn();
    exp_t e;
    do_reset();
    repeat (5) press(K_INC);
    repeat (2) press(K_LEFT);
    repeat (3) press(K_INC);
    push("dn", 0, 305, 0, 0, 0);
    push("dn", 9, 305, 0, 0, 0);
    push("dn", 10, 304, 0, 0, 0);
    push("dn", 49, 301, 0, 0, 0);
    push("dn", 50, 300, 0, 1, 0);
    push("dn", 59, 300, 0, 1, 0);
    push("dn", 60, 299, ALL, 1, 0);
    push("dn", 69, 299, ALL, 1, 0);
    push("dn", 70, 298, 0, 1, 0);
    push("dn", 80, 297, ALL, 1, 0);
    push("dn", 3049, 1, ALL, 1, 0);
    push("dn", 3050, 0, ALL, 0, 1);
    push("dn", 3055, 0, ALL, 0, 1);
    bus.count_up = 1'b0;
    bus.key_state = K_START;
    for (int c = 0; c <= 3055; c++) begin
      cyc(1);
      bus.key_state = '0;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_run++;
        if ({bus.number_to_show, bus.shank_position, bus.warn,
             bus.done} !== {e.num, e.shank, e.warn, e.done}) begin
          n_fail++;
          $display("FAIL %s@%0d: num=%0d shank=%b warn=%b done=%b, want num=%0d shank=%b warn=%b done=%b",
                   e.name, e.cyc, bus.number_to_show, bus.shank_position,
                   bus.warn, bus.done, e.num, e.shank, e.warn, e.done);
        end
      end
    end
  endtask

  task automatic test_up_mode();
    exp_t e;
    do_reset();
    press(K_LEFT);
    repeat (2) press(K_INC);
    push("up", 0, 0, 0, 0, 0);
    push("up", 1, 0, 0, 1, 0);
    push("up", 9, 0, 0, 1, 0);
    push("up", 10, 1, ALL, 1, 0);
    push("up", 20, 2, 0, 1, 0);
    push("up", 199, 19, ALL, 1, 0);
    push("up", 200, 20, ALL, 0, 1);
    push("up", 205, 20, ALL, 0, 1);
    bus.count_up = 1'b1;
    bus.key_state = K_START;
    for (int c = 0; c <= 205; c++) begin
      cyc(1);
      bus.key_state = '0;
      bus.count_up = 1'b0;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_run++;
        if ({bus.number_to_show, bus.shank_position, bus.warn,
             bus.done} !== {e.num, e.shank, e.warn, e.done}) begin
          n_fail++;
          $display("FAIL %s@%0d: num=%0d shank=%b warn=%b done=%b, want num=%0d shank=%b warn=%b done=%b",
                   e.name, e.cyc, bus.number_to_show, bus.shank_position,
                   bus.warn, bus.done, e.num, e.shank, e.warn, e.done);
        end
      end
    end
  endtask

  task automatic test_pause();
    exp_t e;
    push("pause", 0, 20, 0, 0, 0);
    push("pause", 4, 20, 0, 1, 0);
    push("pause", 5, 20, 0, 1, 0);
    push("pause", 41, 20, 0, 1, 0);
    push("pause", 42, 20, 0, 1, 0);
    push("pause", 47, 20, 0, 1, 0);
    push("pause", 48, 19, ALL, 1, 0);
    push("pause", 237, 1, ALL, 1, 0);
    push("pause", 238, 0, ALL, 0, 1);
    push("pause", 245, 0, ALL, 0, 1);
    bus.count_up = 1'b0;
    bus.key_state = K_START;
    for (int c = 0; c <= 245; c++) begin
      cyc(1);
      bus.key_state = ((c >= 4 && c < 41) || c >= 240)
                    ? K_PAUSE : '0;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_run++;
        if ({bus.number_to_show, bus.shank_position, bus.warn,
             bus.done} !== {e.num, e.shank, e.warn, e.done}) begin
          n_fail++;
          $display("FAIL %s@%0d: num=%0d shank=%b warn=%b done=%b, want num=%0d shank=%b warn=%b done=%b",
                   e.name, e.cyc, bus.number_to_show, bus.shank_position,
                   bus.warn, bus.done, e.num, e.shank, e.warn, e.done);
        end
      end
    end
    bus.key_state = '0;
    cyc(1);
  endtask

  task automatic test_abort();
    exp_t e;
    push("abort", 0, 20, 0, 0, 0);
    push("abort", 14, 19, ALL, 1, 0);
    push("abort", 15, 20, 16, 0, 0);
    push("abort", 16, 20, 16, 0, 0);
    bus.count_up = 1'b0;
    bus.key_state = K_START;
    for (int c = 0; c <= 16; c++) begin
      cyc(1);
      bus.key_state = (c == 14) ? K_ABORT : '0;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_run++;
        if ({bus.number_to_show, bus.shank_position, bus.warn,
             bus.done} !== {e.num, e.shank, e.warn, e.done}) begin
          n_fail++;
          $display("FAIL %s@%0d: num=%0d shank=%b warn=%b done=%b, want num=%0d shank=%b warn=%b done=%b",
                   e.name, e.cyc, bus.number_to_show, bus.shank_position,
                   bus.warn, bus.done, e.num, e.shank, e.warn, e.done);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    push("mid", 12, 19, ALL, 1, 0);
    push("rst_async", 31, 0, 0, 0, 0);
    push("rst_set", 32, 0, 32, 0, 0);
    bus.count_up = 1'b0;
    bus.key_state = K_START;
    for (int c = 0; c <= 32; c++) begin
      if (c < 31) begin
        cyc(1);
        bus.key_state = '0;
      end else if (c == 31) begin
        #2;
        rst_n = 1'b0;
        #1;
      end else begin
        rst_n = 1'b1;
        cyc(1);
      end
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_run++;
        if ({bus.number_to_show, bus.shank_position, bus.warn,
             bus.done} !== {e.num, e.shank, e.warn, e.done}) begin
          n_fail++;
          $display("FAIL %s@%0d: num=%0d shank=%b warn=%b done=%b, want num=%0d shank=%b warn=%b done=%b",
                   e.name, e.cyc, bus.number_to_show, bus.shank_position,
                   bus.warn, bus.done, e.num, e.shank, e.warn, e.done);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_run = 0;
    n_fail = 0;
    m_preset = 0;
    m_idx = ND - 1;
    bus.key_state = '0;
    bus.count_up = 1'b0;
    test_reset();
    test_edit();
    test_saturate();
    test_zero_start();
    test_down_warn();
    test_up_mode();
    test_pause();
    test_abort();
    test_reset_mid_run();
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: %0d left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
